// File: rtl/line_mem_responder.sv
// ============================================================================
// Module   : line_mem_responder
// Brief    : Fixed-latency line memory model answering level-held cache reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_mem_responder #(
    parameter int Latency      = 4,
    parameter int LineAddrBits = 10,
    parameter int LineSize     = 128
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [31:0]             mem_addr_i,
    input  logic                    mem_read_en_i,
    output logic                    mem_read_valid_o,
    output logic [LineSize-1:0]     mem_read_data_o,
    output logic                    busy_o,
    input  logic                    init_we_i,
    input  logic [LineAddrBits-1:0] init_line_i,
    input  logic [LineSize-1:0]     init_data_i
);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_wait    = 2'd1;
    localparam logic [1:0] c_resp    = 2'd2;
    localparam logic [1:0] c_release = 2'd3;

    localparam logic [7:0] c_cnt_load = 8'(Latency - 1);

    logic [1:0]              r_state;
    logic [7:0]              r_cnt;
    logic [LineAddrBits-1:0] r_line;
    logic [LineSize-1:0]     r_data;
    logic [LineSize-1:0]     r_mem [2**LineAddrBits];

    logic [LineAddrBits-1:0] w_line;
    logic                    w_unused_addr;

    // Upper address bits wrap; the low nibble is the byte offset inside a line.
    assign w_line        = mem_addr_i[4+LineAddrBits-1:4];
    assign w_unused_addr = ^{mem_addr_i[31:4+LineAddrBits], mem_addr_i[3:0]};

    // Storage has no reset so preloaded contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (init_we_i) begin
            r_mem[init_line_i] <= init_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_idle;
            r_cnt   <= 8'd0;
            r_line  <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (mem_read_en_i) begin
                        r_line <= w_line;
                        r_cnt  <= c_cnt_load;
                        if (Latency == 1) begin
                            r_state <= c_resp;
                            r_data  <= r_mem[w_line];
                        end else begin
                            r_state <= c_wait;
                        end
                    end
                end
                c_wait: begin
                    // Array read here sees pre-write contents on an init collision.
                    if (r_cnt == 8'd0) begin
                        r_state <= c_resp;
                        r_data  <= r_mem[r_line];
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                c_resp: begin
                    r_state <= c_release;
                end
                c_release: begin
                    // Held requests park here so they are never served twice.
                    if (!mem_read_en_i) begin
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign mem_read_valid_o = (r_state == c_resp);
    assign busy_o           = (r_state != c_idle);
    assign mem_read_data_o  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_line_mem_responder.sv
// ============================================================================
// Module   : tb_line_mem_responder
// Brief    : Directed self-checking bench for line_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_mem_responder;

    localparam logic [127:0] c_d5  = 128'h0000000D_0000000C_0000000B_0000000A;
    localparam logic [127:0] c_d6  = 128'h66666666_55555555_44444444_33333333;
    localparam logic [127:0] c_new = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic         en;
    logic         valid;
    logic [127:0] rdata;
    logic         busy;
    logic [31:0]  addr1;
    logic         en1;
    logic         valid1;
    logic [127:0] rdata1;
    logic         busy1;
    logic         init_we;
    logic [9:0]   init_line;
    logic [127:0] init_data;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    line_mem_responder #(.Latency(4), .LineAddrBits(10), .LineSize(128)) dut (
        .clk_i(clk), .rst_i(rst), .mem_addr_i(addr), .mem_read_en_i(en),
        .mem_read_valid_o(valid), .mem_read_data_o(rdata), .busy_o(busy),
        .init_we_i(init_we), .init_line_i(init_line), .init_data_i(init_data)
    );

    line_mem_responder #(.Latency(1), .LineAddrBits(10), .LineSize(128)) dut1 (
        .clk_i(clk), .rst_i(rst), .mem_addr_i(addr1), .mem_read_en_i(en1),
        .mem_read_valid_o(valid1), .mem_read_data_o(rdata1), .busy_o(busy1),
        .init_we_i(init_we), .init_line_i(init_line), .init_data_i(init_data)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Issues one request, waits (bounded) for the pulse, then releases en.
    task automatic read_line(input logic [31:0] a, output logic [127:0] d,
                             output int lat, output int pulses);
        addr = a;
        en   = 1'b1;
        step();
        lat    = -1;
        pulses = 0;
        d      = '0;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            step();
            if (valid) begin
                lat = k;
                d   = rdata;
                pulses++;
            end
        end
        en = 1'b0;
        step();
        if (valid) pulses++;
        step();
        if (valid) pulses++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({valid, busy, valid1, busy1} !== 4'b0000) begin
            $display("FAIL reset_ctrl: got %b, want 0000", {valid, busy, valid1, busy1});
        end else passes++;
        checks++;
        if (rdata !== 128'd0 || rdata1 !== 128'd0) begin
            $display("FAIL reset_data: got %h / %h, want 0", rdata, rdata1);
        end else passes++;
        rst = 1'b0;
    endtask

    task automatic preload(input logic [9:0] line, input logic [127:0] d);
        init_we   = 1'b1;
        init_line = line;
        init_data = d;
        step();
        init_we = 1'b0;
    endtask

    task automatic test_basic;
        logic [127:0] d;
        int lat, pulses;
        read_line(32'h50, d, lat, pulses);
        checks++;
        if (lat !== 4) $display("FAIL basic_latency: got %0d, want 4", lat);
        else passes++;
        checks++;
        if (d !== c_d5) $display("FAIL basic_data: got %h, want %h", d, c_d5);
        else passes++;
        checks++;
        if (pulses !== 1) $display("FAIL basic_pulses: got %0d, want 1", pulses);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL basic_idle: busy got %b, want 0", busy);
        else passes++;
    endtask

    task automatic test_held;
        int pulses = 0;
        addr = 32'h50;
        en   = 1'b1;
        step();
        for (int k = 1; k <= 14; k++) begin
            step();
            if (valid) pulses++;
        end
        checks++;
        if (pulses !== 1) $display("FAIL held_pulses: got %0d, want 1", pulses);
        else passes++;
        checks++;
        if (busy !== 1'b1) $display("FAIL held_busy: got %b, want 1", busy);
        else passes++;
        en = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) $display("FAIL held_release: busy got %b, want 0", busy);
        else passes++;
    endtask

    task automatic test_wrap;
        int lat = -1;
        logic [127:0] d = '0;
        addr = 32'h0000_4058;
        en   = 1'b1;
        step();
        step();
        addr = 32'h60;
        for (int k = 2; k <= 20 && lat < 0; k++) begin
            step();
            if (valid) begin
                lat = k;
                d   = rdata;
            end
        end
        checks++;
        if (lat !== 4) $display("FAIL wrap_latency: got %0d, want 4", lat);
        else passes++;
        checks++;
        if (d !== c_d5) $display("FAIL wrap_data: got %h, want %h", d, c_d5);
        else passes++;
        en = 1'b0;
        step();
        step();
    endtask

    task automatic test_latency1;
        addr1 = 32'h60;
        en1   = 1'b1;
        checks++;
        if (valid1 !== 1'b0) $display("FAIL lat1_pre: valid got %b, want 0", valid1);
        else passes++;
        step();
        checks++;
        if (valid1 !== 1'b1 || rdata1 !== c_d6)
            $display("FAIL lat1_resp: valid %b data %h, want 1 %h", valid1, rdata1, c_d6);
        else passes++;
        en1 = 1'b0;
        step();
        checks++;
        if (valid1 !== 1'b0 || busy1 !== 1'b1)
            $display("FAIL lat1_release: valid %b busy %b, want 0 1", valid1, busy1);
        else passes++;
        step();
        checks++;
        if (busy1 !== 1'b0) $display("FAIL lat1_idle: busy got %b, want 0", busy1);
        else passes++;
    endtask

    task automatic test_back_to_back;
        int lat = -1;
        logic [127:0] d = '0;
        addr = 32'h50;
        en   = 1'b1;
        step();
        for (int k = 1; k <= 20 && !valid; k++) step();
        step();
        en = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) $display("FAIL b2b_gap: busy got %b, want 0", busy);
        else passes++;
        addr = 32'h60;
        en   = 1'b1;
        step();
        checks++;
        if (busy !== 1'b1) $display("FAIL b2b_accept: busy got %b, want 1", busy);
        else passes++;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            step();
            if (valid) begin
                lat = k;
                d   = rdata;
            end
        end
        checks++;
        if (lat !== 4 || d !== c_d6)
            $display("FAIL b2b_second: lat %0d data %h, want 4 %h", lat, d, c_d6);
        else passes++;
        en = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid_wait;
        int pulses = 0;
        logic [127:0] d;
        int lat, p2;
        addr = 32'h50;
        en   = 1'b1;
        step();
        step();
        rst = 1'b1;
        en  = 1'b0;
        step();
        checks++;
        if ({valid, busy} !== 2'b00 || rdata !== 128'd0)
            $display("FAIL rst_wait_state: valid %b busy %b data %h, want 0 0 0", valid, busy, rdata);
        else passes++;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (valid || busy) pulses++;
        end
        checks++;
        if (pulses !== 0) $display("FAIL rst_wait_quiet: active cycles %0d, want 0", pulses);
        else passes++;
        read_line(32'h50, d, lat, p2);
        checks++;
        if (d !== c_d5 || lat !== 4 || p2 !== 1)
            $display("FAIL rst_wait_reread: data %h lat %0d pulses %0d, want %h 4 1", d, lat, p2, c_d5);
        else passes++;
    endtask

    task automatic test_collision;
        logic [127:0] d;
        int lat, p2;
        addr = 32'h50;
        en   = 1'b1;
        step();
        for (int k = 1; k <= 3; k++) step();
        checks++;
        if (valid !== 1'b0) $display("FAIL coll_early: valid got %b, want 0", valid);
        else passes++;
        init_we   = 1'b1;
        init_line = 10'h005;
        init_data = c_new;
        step();
        init_we = 1'b0;
        checks++;
        if (valid !== 1'b1 || rdata !== c_d5)
            $display("FAIL coll_old: valid %b data %h, want 1 %h", valid, rdata, c_d5);
        else passes++;
        en = 1'b0;
        step();
        step();
        read_line(32'h50, d, lat, p2);
        checks++;
        if (d !== c_new || lat !== 4)
            $display("FAIL coll_new: data %h lat %0d, want %h 4", d, lat, c_new);
        else passes++;
    endtask

    initial begin
        rst       = 1'b1;
        addr      = '0;
        en        = 1'b0;
        addr1     = '0;
        en1       = 1'b0;
        init_we   = 1'b0;
        init_line = '0;
        init_data = '0;
        test_reset();
        preload(10'h005, c_d5);
        preload(10'h006, c_d6);
        test_basic();
        test_held();
        test_wrap();
        test_latency1();
        test_back_to_back();
        test_reset_mid_wait();
        test_collision();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
